cache_arbiter: RTL and testbench
================================

# cache_arbiter

Sequential arbiter that shares the single RAM port between the instruction cache and the data cache. Registers a grant per transaction, holds it until the RAM reports completion, and steers RAM read data and wait status back to the granted cache. Sits between the two L1 caches and the RAM model/bus, below the caches' miss and writeback state machines.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive dcache grants allowed while an icache request is pending (used only with `ARB_FAIR_EN`).

Ports (`word_t` = 32 bits, `ramstate_t` from `cpu_types_pkg`):
- `CLK`  in  1  clock, all state on rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `iwait`  out  1  low for exactly the completing cycle of an icache transaction.
- `iload`  out  32  RAM read data to icache.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request.
- `daddr`  in  32  dcache address.
- `dstore`  in  32  dcache write data.
- `dwait`  out  1  low for exactly the completing cycle of a dcache transaction.
- `dload`  out  32  RAM read data to dcache.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  `ramstate_t`  FREE / BUSY / ACCESS / ERROR.

## Operation
- States `IDLE`, `IGNT`, `DGNT` (`arb_state_t`); reset to `IDLE`.
- `IDLE`: if `dREN|dWEN`, go to `DGNT`; else if `iREN`, go to `IGNT`; else stay. dcache has priority (subject to `ARB_FAIR_EN`).
- `IGNT` outputs:
  - `ramREN=1`, `ramaddr=iaddr`.
  - `iwait = (ramstate != ACCESS)`.
  - Leave to `IDLE` when `ramstate==ACCESS`.
- `DGNT` outputs:
  - `ramREN=dREN`, `ramWEN=dWEN & ~dREN` (read wins if both asserted).
  - `ramaddr=daddr`, `ramstore=dstore`.
  - `dwait = (ramstate != ACCESS)`.
  - Leave to `IDLE` when `ramstate==ACCESS`.
- Non-granted side: wait held 1.
- Withdrawn request: if the granted requester drops its request before ACCESS, abort to `IDLE` next cycle. No wait pulse is produced.
- `ERROR`: wait stays 1 and the state stays in the grant. The request is reissued until ACCESS.
- `iload = dload = ramload`, passthrough; only valid when the matching wait is low.
- Outside a grant, `ramREN/ramWEN/ramaddr/ramstore` are 0.

## Timing
- Reset values:
  - `iwait=1`, `dwait=1`.
  - `ramREN=0`, `ramWEN=0`, `ramaddr=0`, `ramstore=0`.
  - `iload/dload` follow `ramload`.
- Request sampled in `IDLE` at edge N. RAM signals are asserted from cycle N+1.
- Completion is the cycle with `ramstate==ACCESS`; wait is low combinationally in that cycle.
- Minimum request-to-completion is 1 cycle after the grant. With RAM latency L, completion is at N+1+L.
- There is always one `IDLE` cycle between transactions; back-to-back throughput is one transaction per L+2 cycles.
- Simultaneous `iREN` and `dREN` in `IDLE`: dcache wins. icache is granted after dcache completes, provided `iREN` is still high.
- Reset mid-transaction: immediate return to `IDLE` with all RAM enables 0. An in-flight RAM op is abandoned.

## Configuration
- `CACHE_ARB_FAIR_EN` defined:
  - Starvation counter, width `$clog2(STARVE_LIMIT+1)`, reset 0.
  - Increments on each `IDLE`→`DGNT` transition while `iREN=1`.
  - Cleared on any `IGNT` entry, or in `IDLE` with `iREN=0`.
  - When count == `STARVE_LIMIT` and `iREN=1`, `IDLE` grants icache even if dcache requests.
- Undefined: strict dcache priority, no counter logic.

## Structure
- `cpu_types_pkg`: `arb_state_t` enum. `word_t` and `ramstate_t` are reused from it.
- Sub-module `arb_starve_ctr` (counter + limit compare, saturating):
  - Instantiated only under `CACHE_ARB_FAIR_EN`.
  - Outputs `force_i`.

## Test plan
- Reset with `nRST=0`: `iwait=dwait=1`, `ramREN=ramWEN=0`, `ramaddr=0`. After release, state is `IDLE`.
- `iREN=1`, `iaddr=0x40`, RAM latency 2:
  - From the cycle after the request, `ramREN=1`, `ramaddr=0x40`.
  - `iwait=0` for one cycle, at cycle 3, with `iload=ramload=0xDEADBEEF`.
- `iREN` and `dWEN` rise together with `daddr=0x80`, `dstore=0x1234`:
  - dcache write completes first (`ramWEN=1`, `ramstore=0x1234`).
  - One `IDLE` cycle follows, then the icache read.
- `dREN` dropped before ACCESS: next cycle is `IDLE`, `ramREN=0`, no `dwait` low pulse.
- Under `CACHE_ARB_FAIR_EN` with `STARVE_LIMIT=4`, dcache requesting continuously and `iREN` held: grants go D,D,D,D,I. Without the macro, icache never completes.
- `ramstate=ERROR` for 3 cycles, then ACCESS: wait stays 1 through ERROR and `ramREN` stays 1. Wait pulses low only on ACCESS.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, RAM handshake state and the cache arbiter grant state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of dcache grants taken while icache waits; raises force_i at the limit.
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    input  logic iREN,
    output logic force_i
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != LIM)
            cnt <= cnt + CW'(1);
    end

    assign force_i = iREN && (cnt == LIM);

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single RAM port between icache and dcache, one registered grant per transaction.
// Define CACHE_ARB_FAIR_EN to bound how long dcache priority can starve the icache.
module cache_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);
    arb_state_t state, next_state;
    logic       force_i;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        case (state)
            IDLE: begin
                if (force_i)
                    next_state = IGNT;
                else if (dREN || dWEN)
                    next_state = DGNT;
                else if (iREN)
                    next_state = IGNT;
            end
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = (ramstate != ACCESS);
                // A dropped request aborts the grant; ERROR just keeps reissuing.
                if (ramstate == ACCESS || !iREN)
                    next_state = IDLE;
            end
            DGNT: begin
                ramREN   = dREN;
                ramWEN   = dWEN & ~dREN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = (ramstate != ACCESS);
                if (ramstate == ACCESS || !(dREN || dWEN))
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

`ifdef CACHE_ARB_FAIR_EN
    logic starve_inc, starve_clr;

    assign starve_inc = (state == IDLE) && (next_state == DGNT) && iREN;
    assign starve_clr = (state == IDLE) && (!iREN || next_state == IGNT);

    arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .CLK     (CLK),
        .nRST    (nRST),
        .inc     (starve_inc),
        .clr     (starve_clr),
        .iREN    (iREN),
        .force_i (force_i)
    );
`else
    logic unused_starve_limit;

    assign force_i             = 1'b0;
    assign unused_starve_limit = (STARVE_LIMIT > 0);
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized two-cache traffic.
module tb_cache_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;

    // RAM model knobs and state
    int    cfg_lat = 1;
    int    cfg_err = 0;
    bit    ram_rand = 1'b0;
    int    rl = 1;
    int    re = 0;
    int    ram_cnt = 0;
    word_t mem     [0:255];
    word_t ref_mem [0:255];
    bit    mon_en = 1'b0;
    bit    prev_done = 1'b0;

    always #5 CLK = ~CLK;

    cache_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    // RAM: L busy cycles, then E error cycles, then ACCESS.
    always_comb begin
        int lat, err;
        lat = ram_rand ? rl : cfg_lat;
        err = ram_rand ? re : cfg_err;
        if (!(ramREN || ramWEN))      ramstate = FREE;
        else if (ram_cnt >= lat + err) ramstate = ACCESS;
        else if (ram_cnt >= lat)       ramstate = ERROR;
        else                           ramstate = BUSY;
    end

    always_comb ramload = (ramstate == ACCESS) ? mem[ramaddr[7:0]] : {24'hC0FFEE, ramaddr[7:0]};

    always @(posedge CLK) begin
        if ((ramREN || ramWEN) && ramstate != ACCESS) ram_cnt <= ram_cnt + 1;
        else                                          ram_cnt <= 0;
        if (ramstate == ACCESS) begin
            if (ramWEN) mem[ramaddr[7:0]] = ramstore;
            rl <= $urandom_range(0, 3);
            re <= ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        end
    end

    // Global invariants during random traffic.
    always @(negedge CLK) begin
        if (mon_en) begin
            checks++;
            if (!iwait && !dwait) begin
                errors++;
                $display("FAIL both_wait_low: iwait=%b dwait=%b required one high", iwait, dwait);
            end
            if (prev_done) begin
                checks++;
                if ({ramREN, ramWEN} !== 2'b00) begin
                    errors++;
                    $display("FAIL idle_gap: ramREN/WEN=%b required 00", {ramREN, ramWEN});
                end
            end
            prev_done = !iwait || !dwait;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_pt();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b1; dWEN = 1'b1; dREN = 1'b0;
        iaddr = 32'h4; daddr = 32'h8; dstore = 32'h99;
        @(negedge CLK);
        checks++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100 || ramaddr !== 0 || ramstore !== 0) begin
            errors++;
            $display("FAIL reset_outputs: w/w/ren/wen=%b addr=%h store=%h required 1100 0 0",
                     {iwait, dwait, ramREN, ramWEN}, ramaddr, ramstore);
        end
        checks++;
        if (iload !== ramload || dload !== ramload) begin
            errors++;
            $display("FAIL reset_load: iload=%h dload=%h required %h", iload, dload, ramload);
        end
        iREN = 1'b0; dWEN = 1'b0;
        drive_pt();
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
            errors++;
            $display("FAIL post_reset_idle: w/w/ren/wen=%b required 1100", {iwait, dwait, ramREN, ramWEN});
        end
        // Reset in the middle of a dcache write.
        drive_pt();
        cfg_lat = 3; dWEN = 1'b1; daddr = 32'h10; dstore = 32'h55;
        @(posedge CLK);
        #2;
        checks++;
        if (ramWEN !== 1'b1 || ramaddr !== 32'h10) begin
            errors++;
            $display("FAIL midreset_pre: ramWEN=%b addr=%h required 1 00000010", ramWEN, ramaddr);
        end
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({ramREN, ramWEN} !== 2'b00 || ramaddr !== 0 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL midreset: ren/wen=%b addr=%h dwait=%b required 00 0 1",
                     {ramREN, ramWEN}, ramaddr, dwait);
        end
        dWEN = 1'b0;
        drive_pt();
        nRST = 1'b1;
        drive_pt();
    endtask

    task automatic test_iread();
        cfg_lat = 2; cfg_err = 0;
        mem[8'h40] = 32'hDEADBEEF; ref_mem[8'h40] = 32'hDEADBEEF;
        iREN = 1'b1; iaddr = 32'h40;
        @(posedge CLK);
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            checks++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== (c != 3)) begin
                errors++;
                $display("FAIL iread_c%0d: ren=%b addr=%h iwait=%b required 1 00000040 %b",
                         c, ramREN, ramaddr, iwait, (c != 3));
            end
            if (c == 3) begin
                checks++;
                if (iload !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL iread_data: iload=%h required deadbeef", iload);
                end
            end
        end
        drive_pt();
        iREN = 1'b0;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            errors++;
            $display("FAIL iread_idle: ren=%b iwait=%b required 0 1", ramREN, iwait);
        end
        drive_pt();
    endtask

    task automatic test_priority();
        cfg_lat = 1;
        iREN = 1'b1; iaddr = 32'h44;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0111 || ramaddr !== 32'h80 || ramstore !== 32'h1234) begin
            errors++;
            $display("FAIL prio_dgnt: ren/wen/iw/dw=%b addr=%h store=%h required 0111 80 1234",
                     {ramREN, ramWEN, iwait, dwait}, ramaddr, ramstore);
        end
        @(negedge CLK);
        checks++;
        if ({ramWEN, iwait, dwait} !== 3'b110) begin
            errors++;
            $display("FAIL prio_dcomplete: wen/iw/dw=%b required 110", {ramWEN, iwait, dwait});
        end
        ref_mem[8'h80] = 32'h1234;
        drive_pt();
        dWEN = 1'b0;
        @(negedge CLK);
        checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            errors++;
            $display("FAIL prio_gap: ren/wen/iw/dw=%b required 0011", {ramREN, ramWEN, iwait, dwait});
        end
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h44 || iwait !== 1'b1) begin
            errors++;
            $display("FAIL prio_igrant: ren=%b addr=%h iwait=%b required 1 44 1", ramREN, ramaddr, iwait);
        end
        @(negedge CLK);
        checks++;
        if (iwait !== 1'b0 || iload !== ref_mem[8'h44]) begin
            errors++;
            $display("FAIL prio_icomplete: iwait=%b iload=%h required 0 %h", iwait, iload, ref_mem[8'h44]);
        end
        drive_pt();
        iREN = 1'b0;
        checks++;
        if (mem[8'h80] !== 32'h1234) begin
            errors++;
            $display("FAIL prio_written: mem=%h required 1234", mem[8'h80]);
        end
        drive_pt();
    endtask

    task automatic test_withdraw();
        bit seen_low;
        cfg_lat = 3;
        dREN = 1'b1; daddr = 32'h10;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL wd_grant: ren=%b dwait=%b required 1 1", ramREN, dwait);
        end
        drive_pt();
        dREN = 1'b0;
        seen_low = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge CLK);
            if (!dwait) seen_low = 1'b1;
            if (c == 3) begin
                checks++;
                if ({ramREN, ramWEN} !== 2'b00) begin
                    errors++;
                    $display("FAIL wd_idle: ren/wen=%b required 00", {ramREN, ramWEN});
                end
            end
        end
        checks++;
        if (seen_low) begin
            errors++;
            $display("FAIL wd_nopulse: dwait pulsed low=%b required 0", seen_low);
        end
        drive_pt();
    endtask

    task automatic test_error();
        cfg_lat = 1; cfg_err = 3;
        iREN = 1'b1; iaddr = 32'h20;
        @(posedge CLK);
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            checks++;
            if (ramREN !== 1'b1 || iwait !== (c != 5)) begin
                errors++;
                $display("FAIL err_c%0d: ren=%b iwait=%b required 1 %b", c, ramREN, iwait, (c != 5));
            end
        end
        checks++;
        if (iload !== ref_mem[8'h20]) begin
            errors++;
            $display("FAIL err_data: iload=%h required %h", iload, ref_mem[8'h20]);
        end
        drive_pt();
        iREN = 1'b0; cfg_err = 0;
        drive_pt();
    endtask

    task automatic test_starve();
        byte g [5];
        byte e [5];
        int  n;
`ifdef CACHE_ARB_FAIR_EN
        e = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49};
`else
        e = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
`endif
        cfg_lat = 1;
        n = 0;
        iREN = 1'b1; iaddr = 32'h30;
        dREN = 1'b1; daddr = 32'h34;
        for (int k = 0; k < 60 && n < 5; k++) begin
            @(negedge CLK);
            if (!dwait)      begin g[n] = 8'h44; n++; end
            else if (!iwait) begin g[n] = 8'h49; n++; end
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL starve_count: completions=%0d required 5", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (g[i] !== e[i]) begin
                errors++;
                $display("FAIL starve_grant%0d: got %c required %c", i, g[i], e[i]);
            end
        end
        drive_pt();
        iREN = 1'b0; dREN = 1'b0;
        repeat (2) drive_pt();
    endtask

    task automatic test_random();
        ram_rand = 1'b1;
        mon_en   = 1'b1;
        fork
            begin : icache
                for (int t = 0; t < 30; t++) begin
                    int  a;
                    bit  done;
                    a = $urandom_range(0, 255);
                    iaddr = a; iREN = 1'b1; done = 1'b0;
                    for (int k = 0; k < 80 && !done; k++) begin
                        @(negedge CLK);
                        if (!iwait) begin
                            done = 1'b1;
                            checks++;
                            if (iload !== ref_mem[a] || ramaddr !== word_t'(a) || ramREN !== 1'b1) begin
                                errors++;
                                $display("FAIL rnd_iread: addr=%h data=%h required %h %h",
                                         ramaddr, iload, a, ref_mem[a]);
                            end
                        end
                    end
                    if (!done) begin
                        errors++;
                        $display("FAIL rnd_itimeout: txn %0d iwait=%b required 0", t, iwait);
                    end
                    drive_pt();
                    iREN = 1'b0;
                    repeat ($urandom_range(0, 3)) drive_pt();
                end
            end
            begin : dcache
                for (int t = 0; t < 30; t++) begin
                    int    a;
                    bit    wr, done;
                    word_t d;
                    a = $urandom_range(0, 255); wr = 1'($urandom_range(0, 1)); d = $urandom;
                    daddr = a; dstore = d; dWEN = wr; dREN = !wr; done = 1'b0;
                    for (int k = 0; k < 80 && !done; k++) begin
                        @(negedge CLK);
                        if (!dwait) begin
                            done = 1'b1;
                            checks++;
                            if (wr) begin
                                if ({ramREN, ramWEN} !== 2'b01 || ramaddr !== word_t'(a) || ramstore !== d) begin
                                    errors++;
                                    $display("FAIL rnd_dwrite: ren/wen=%b addr=%h store=%h required 01 %h %h",
                                             {ramREN, ramWEN}, ramaddr, ramstore, a, d);
                                end
                                ref_mem[a] = d;
                            end else if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== word_t'(a) ||
                                         dload !== ref_mem[a]) begin
                                errors++;
                                $display("FAIL rnd_dread: ren/wen=%b addr=%h data=%h required 10 %h %h",
                                         {ramREN, ramWEN}, ramaddr, dload, a, ref_mem[a]);
                            end
                        end
                    end
                    if (!done) begin
                        errors++;
                        $display("FAIL rnd_dtimeout: txn %0d dwait=%b required 0", t, dwait);
                    end
                    drive_pt();
                    dREN = 1'b0; dWEN = 1'b0;
                    repeat ($urandom_range(1, 3)) drive_pt();
                end
            end
        join
        mon_en   = 1'b0;
        ram_rand = 1'b0;
        drive_pt();
    endtask

    initial begin
        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_iread();
        test_priority();
        test_withdraw();
        test_error();
        test_starve();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
